rom_sequencer: RTL and testbench
================================

ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the ROM word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, meaning the ROM address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter ROM_INIT, default the package table DEFAULT_ROM, meaning the ROM contents, one entry per address.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a burst; sampled only in IDLE.
REQ-007 The block SHALL have port start_addr, input, ADDR_WIDTH bits: first logical address of the burst.
REQ-008 The block SHALL have port length, input, ADDR_WIDTH+1 bits: words per pass, 1..DEPTH; 0 means DEPTH; values above DEPTH are clamped to DEPTH.
REQ-009 The block SHALL have port reverse, input, 1 bit: physical address = DEPTH-1-logical address.
REQ-010 The block SHALL have port loop, input, 1 bit: repeat the pass until abort.
REQ-011 The block SHALL have port abort, input, 1 bit: terminate any burst.
REQ-012 The block SHALL have port out_data, output, DATA_WIDTH bits: ROM word.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-015 The block SHALL have port out_last, output, 1 bit: the current word is the last word of a pass.
REQ-016 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal burst completion.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DRAIN.
- IDLE -> RUN: on start=1 and abort=0.
- RUN -> DRAIN: after the final address of a non-loop burst is issued.
- DRAIN -> IDLE: when the last word is accepted.
- Any state -> IDLE: on abort.
REQ-019 start, start_addr, length, reverse and loop SHALL be captured on the accepting edge; later changes SHALL have no effect until the next burst.
REQ-020 Logical address k of a pass SHALL be (start_addr + k) mod DEPTH, for k = 0..length-1; wrap-around past DEPTH-1 goes to 0.
REQ-021 The ROM read SHALL be synchronous with 1-cycle latency; the first out_valid SHALL rise 2 cycles after the start edge.
REQ-022 A transfer SHALL occur on an edge where out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-023 With out_ready held at 1, the block SHALL sustain one word per cycle with no bubbles, including across loop restarts.
REQ-024 out_last SHALL be 1 exactly on word length-1 of every pass.
REQ-025 done SHALL pulse for 1 cycle on the edge after the last word of a non-loop burst transfers; done SHALL never assert in loop mode or after abort.
REQ-026 Abort SHALL have priority over every other event:
- out_valid is 0 on the next cycle;
- the in-flight word is discarded;
- the FSM returns to IDLE;
- a start on the same edge is ignored.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 out_data SHALL retain its last value when out_valid=0.

Reset
REQ-029 On reset_n=0 at a clock edge, the block SHALL set FSM=IDLE, out_valid=0, out_last=0, busy=0, done=0 and out_data=0, and all captured configuration SHALL be cleared.
REQ-030 Reset mid-burst SHALL discard the burst with no done pulse; ROM contents SHALL be unaffected.

Structure
REQ-031 Package rom_seq_pkg SHALL hold:
- the state enum typedef;
- DEFAULT_ROM, the 8x8 table for addresses 0..7 = AA, F0, 0F, CC, E7, 18, B7, ED (hex);
- a length-normalisation function (0 and values above DEPTH map to DEPTH).
REQ-032 One sub-module, rom_sync_core, SHALL hold the ROM array with a registered read and a read-enable input; the FSM, address generator and output stage SHALL live in rom_sequencer.

Verification
REQ-033 Forward burst: start_addr=2, length=3, reverse=0, loop=0, ready=1 -> 0F, CC, E7 on consecutive cycles, last on E7, done on the next cycle.
REQ-034 Wrap-around: start_addr=6, length=4 -> B7, ED, AA, F0, last on F0.
REQ-035 Reverse: start_addr=0, length=2, reverse=1 -> ED, B7.
REQ-036 Backpressure: start_addr=0, length=3, out_ready toggling 1,0,0,1,... -> AA, F0, 0F each accepted once, data stable while stalled, no loss and no duplication.
REQ-037 Loop and abort: start_addr=4, length=2, loop=1, ready=1 -> E7, 18, E7, 18, ... with last on each 18; abort -> out_valid=0 next cycle, busy=0, no done.
REQ-038 Length and reset cases:
- length=0 -> 8 words, AA..ED;
- reset_n=0 mid-burst -> all outputs 0 the next cycle, no done;
- start during busy -> ignored.

Source files
------------

// File: rtl/rom_sequencer_pkg.sv
// ============================================================================
// Module  : rom_seq_pkg
// Purpose : Shared state encoding, default ROM image and length helper for
//           the ROM burst sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rom_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // Address i occupies bits [8*i +: 8]; address 0 (AA) is the least significant byte.
  localparam logic [63:0] DEFAULT_ROM = {8'hED, 8'hB7, 8'h18, 8'hE7,
                                         8'hCC, 8'h0F, 8'hF0, 8'hAA};

  // A pass length of 0, or one larger than the ROM, means one full sweep.
  function automatic int unsigned norm_length(input int unsigned len,
                                              input int unsigned depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rom_sync_core.sv
// ============================================================================
// Module  : rom_sync_core
// Purpose : Constant ROM with a registered, read-enabled output port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_sync_core
  import rom_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] ROM_INIT = DEFAULT_ROM
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] w_rom [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign w_rom[gi] = ROM_INIT[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Output holds while the read enable is low so a stalled consumer sees stable data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (i_rd_en) begin
      r_data <= w_rom[i_addr];
    end
  end

  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/rom_sequencer.sv
// ============================================================================
// Module  : rom_sequencer
// Purpose : Streams bursts of ROM words (forward/reverse, wrapping, looping)
//           over a valid/ready interface with abort and backpressure.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_sequencer
  import rom_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] ROM_INIT = DEFAULT_ROM
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  reverse,
  input  logic                  loop,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LEN_W = ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_start_addr;
  logic [LEN_W-1:0]      r_len;
  logic                  r_rev;
  logic                  r_loop;
  logic [LEN_W-1:0]      r_k;
  logic                  r_s1_vld;
  logic                  r_s1_last;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_done;

  logic                  w_adv;
  logic                  w_issue;
  logic                  w_k_last;
  logic                  w_final_xfer;
  logic [ADDR_WIDTH-1:0] w_log_addr;
  logic [ADDR_WIDTH-1:0] w_phys_addr;
  logic [DATA_WIDTH-1:0] w_rom_data;

  // Two-stage pipeline (ROM register, output register) that advances as one
  // whenever the output slot is empty or being consumed.
  assign w_adv        = !r_out_valid || out_ready;
  assign w_issue      = (r_state == S_RUN) && w_adv && !abort;
  assign w_k_last     = (r_k == (r_len - LEN_W'(1)));
  assign w_final_xfer = (r_state == S_DRAIN) && r_out_valid && out_ready && r_out_last;
  assign w_log_addr   = r_start_addr + r_k[ADDR_WIDTH-1:0];
  // DEPTH-1-x is the bitwise inverse of x for a power-of-two depth.
  assign w_phys_addr  = r_rev ? ~w_log_addr : w_log_addr;

  rom_sync_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROM_INIT   (ROM_INIT)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .i_rd_en (w_issue),
    .i_addr  (w_phys_addr),
    .o_data  (w_rom_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_start_addr <= '0;
      r_len        <= '0;
      r_rev        <= 1'b0;
      r_loop       <= 1'b0;
      r_k          <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_start_addr <= start_addr;
            r_len        <= LEN_W'(norm_length(32'(length), 32'(DEPTH)));
            r_rev        <= reverse;
            r_loop       <= loop;
            r_k          <= '0;
            r_state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_adv) begin
            if (w_k_last) begin
              r_k <= '0;
              if (!r_loop) begin
                r_state <= S_DRAIN;
              end
            end else begin
              r_k <= r_k + LEN_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (w_final_xfer) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Abort empties both pipeline stages; out_data keeps its last value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_vld    <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      r_s1_vld    <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_final_xfer;
      if (w_adv) begin
        r_s1_vld    <= w_issue;
        r_s1_last   <= w_issue && w_k_last;
        r_out_valid <= r_s1_vld;
        r_out_last  <= r_s1_vld && r_s1_last;
        if (r_s1_vld) begin
          r_out_data <= w_rom_data;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rom_sequencer.sv
// ============================================================================
// Module  : tb_rom_sequencer
// Purpose : Self-checking bench for rom_sequencer (vector table, hand-written
//           corner sequences and randomized bursts against a reference model).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rom_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] length;
  logic       reverse;
  logic       loop;
  logic       abort;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] romv [8] = '{8'hAA, 8'hF0, 8'h0F, 8'hCC, 8'hE7, 8'h18, 8'hB7, 8'hED};
  logic [7:0] exp_q [$];

  typedef struct {
    logic [2:0]  sa;
    logic [3:0]  len;
    logic        rv;
    int          rmode;
    logic        sbusy;
    int          nwords;
    logic [63:0] words;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  rom_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .reverse    (reverse),
    .loop       (loop),
    .abort      (abort),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the words of one pass, straight from the addressing rules.
  task automatic model(input logic [2:0] sa, input logic [3:0] len, input logic rv);
    int l;
    int a;
    exp_q.delete();
    l = (len == 0 || len > 8) ? 8 : int'(len);
    for (int k = 0; k < l; k++) begin
      a = (int'(sa) + k) % 8;
      if (rv) a = 7 - a;
      exp_q.push_back(romv[a]);
    end
  endtask

  // Runs one non-loop burst and compares transfers against exp_q.
  task automatic do_burst(input logic [2:0] sa, input logic [3:0] len, input logic rv,
                          input int rmode, input logic sbusy, input string nm);
    int idx, c, first_c;
    logic held, hl, pend, fin;
    logic [7:0] hd;
    start = 1'b1; start_addr = sa; length = len; reverse = rv; loop = 1'b0; out_ready = 1'b0;
    tick();
    // Scramble the live configuration; only the captured values may matter.
    start = sbusy; start_addr = ~sa; length = 4'd1; reverse = ~rv; loop = 1'b1;
    idx = 0; c = 0; first_c = -1; held = 1'b0; hl = 1'b0; hd = '0; pend = 1'b0; fin = 1'b0;
    while (!fin && c < 300) begin
      if (c >= 3) start = 1'b0;
      if (pend) begin
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " busy_end"}, 32'(busy), 32'd0);
        chk({nm, " valid_end"}, 32'(out_valid), 32'd0);
        fin = 1'b1;
      end else begin
        if (done) chk({nm, " early_done"}, 32'(done), 32'd0);
        if (out_valid && first_c < 0) first_c = c;
        if (held) begin
          chk({nm, " stall_valid"}, 32'(out_valid), 32'd1);
          chk({nm, " stall_data"}, 32'(out_data), 32'(hd));
          chk({nm, " stall_last"}, 32'(out_last), 32'(hl));
        end
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = (c % 3 == 2);
          default: out_ready = 1'($urandom % 2);
        endcase
        if (out_valid && out_ready) begin
          if (idx < exp_q.size()) begin
            chk({nm, " data"}, 32'(out_data), 32'(exp_q[idx]));
            chk({nm, " last"}, 32'(out_last), 32'(idx == exp_q.size() - 1));
          end else begin
            chk({nm, " extra_word"}, 32'(idx), 32'(exp_q.size()));
          end
          idx++;
          if (idx == exp_q.size()) pend = 1'b1;
        end
        held = out_valid && !out_ready;
        hd = out_data;
        hl = out_last;
        tick();
        c++;
      end
    end
    if (!fin) chk({nm, " timeout_words"}, 32'(idx), 32'(exp_q.size()));
    chk({nm, " first_valid_cycle"}, 32'(first_c), 32'd2);
    start = 1'b0; loop = 1'b0; out_ready = 1'b0;
    tick();
    chk({nm, " done_pulse_1cyc"}, 32'(done), 32'd0);
    chk({nm, " idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; reverse = 1'b0;
    loop = 1'b0; abort = 1'b0; out_ready = 1'b0;

    tbl[0] = '{3'd2, 4'd3, 1'b0, 0, 1'b0, 3, 64'h0000_0000_00E7_CC0F};
    tbl[1] = '{3'd6, 4'd4, 1'b0, 0, 1'b0, 4, 64'h0000_0000_F0AA_EDB7};
    tbl[2] = '{3'd0, 4'd2, 1'b1, 0, 1'b0, 2, 64'h0000_0000_0000_B7ED};
    tbl[3] = '{3'd0, 4'd3, 1'b0, 1, 1'b0, 3, 64'h0000_0000_000F_F0AA};
    tbl[4] = '{3'd0, 4'd0, 1'b0, 0, 1'b0, 8, 64'hEDB7_18E7_CC0F_F0AA};
    tbl[5] = '{3'd3, 4'd9, 1'b0, 0, 1'b0, 8, 64'h0FF0_AAED_B718_E7CC};
    tbl[6] = '{3'd2, 4'd3, 1'b0, 0, 1'b1, 3, 64'h0000_0000_00E7_CC0F};
    tbl[7] = '{3'd5, 4'd8, 1'b1, 0, 1'b0, 8, 64'hCCE7_18B7_EDAA_F00F};
    tbl[8] = '{3'd7, 4'd1, 1'b0, 2, 1'b0, 1, 64'h0000_0000_0000_00ED};

    tick(); tick();
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset data", 32'(out_data), 32'd0);
    chk("reset last", 32'(out_last), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      logic [63:0] w;
      exp_q.delete();
      w = tbl[i].words;
      for (int j = 0; j < tbl[i].nwords; j++) exp_q.push_back(w[8*j +: 8]);
      do_burst(tbl[i].sa, tbl[i].len, tbl[i].rv, tbl[i].rmode, tbl[i].sbusy, $sformatf("vec%0d", i));
    end

    // Loop mode: continuous E7,18 stream, then abort with a simultaneous start.
    start = 1'b1; start_addr = 3'd4; length = 4'd2; reverse = 1'b0; loop = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; loop = 1'b0; length = 4'd5;
    tick(); tick();
    for (int j = 0; j < 12; j++) begin
      chk("loop valid", 32'(out_valid), 32'd1);
      chk("loop data", 32'(out_data), (j % 2 == 1) ? 32'h18 : 32'hE7);
      chk("loop last", 32'(out_last), 32'(j % 2 == 1));
      chk("loop done", 32'(done), 32'd0);
      tick();
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort last", 32'(out_last), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    for (int j = 0; j < 4; j++) begin
      chk("post_abort done", 32'(done), 32'd0);
      chk("post_abort valid", 32'(out_valid), 32'd0);
      tick();
    end

    // Abort in IDLE wins over start.
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("idle_abort busy", 32'(busy), 32'd0);
    tick();
    chk("idle_abort valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a full-length burst.
    start = 1'b1; start_addr = 3'd0; length = 4'd0; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("midreset valid", 32'(out_valid), 32'd0);
    chk("midreset data", 32'(out_data), 32'd0);
    chk("midreset last", 32'(out_last), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    reset_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("post_reset done", 32'(done), 32'd0);
      chk("post_reset valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    model(3'd2, 4'd3, 1'b0);
    do_burst(3'd2, 4'd3, 1'b0, 0, 1'b0, "after_reset");

    // Randomized bursts against the reference model.
    for (int r = 0; r < 30; r++) begin
      logic [2:0] sa;
      logic [3:0] ln;
      logic       rv;
      sa = 3'($urandom_range(0, 7));
      ln = 4'($urandom_range(0, 15));
      rv = 1'($urandom % 2);
      model(sa, ln, rv);
      do_burst(sa, ln, rv, 2, 1'($urandom % 2), $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
